adder_arbiter_16bit: RTL

Shares a single `two_comple_adder_16bit` add/subtract datapath between two requesters, such as PC/branch-target generation and the ALU path. The block arbitrates with round-robin or fixed priority, latches the winner's operands, and runs one add or subtract. It returns a registered result with carry and signed-overflow flags and a one-cycle ACK to the winner.

---
 rtl/adder_arbiter_16bit_pkg.sv | 26 ++
 rtl/two_comple_adder_16bit.sv | 19 +
 rtl/adder_arbiter_16bit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/adder_arbiter_16bit_pkg.sv
// Shared definitions for the arbitrated add/subtract datapath:
// word width, FSM encoding, operand payload and the overflow helper.
package adder_arbiter_16bit_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
  localparam logic [ST_W-1:0] ST_EXEC = 2'd2;
  localparam logic [ST_W-1:0] ST_RESP = 2'd3;

  typedef struct packed {
    logic              sub;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } operand_t;

  // Signed overflow from operand and result sign bits.
  function automatic logic calc_ovf(input logic sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    if (sub) return (a_msb != b_msb) && (r_msb != a_msb);
    else     return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/two_comple_adder_16bit.sv
// Two's-complement add/subtract: S=0 gives A+B, S=1 gives A-B (A + ~B + 1).
// Cout is the raw carry; for subtract it reads 1 when there is no borrow.
module two_comple_adder_16bit
  import adder_arbiter_16bit_pkg::*;
(
  input  logic              S,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic [WORD_W-1:0] Y,
  output logic              Cout
);

  logic [WORD_W:0] sum;

  assign sum  = {1'b0, A} + {1'b0, (S ? ~B : B)} + (WORD_W+1)'(S);
  assign Y    = sum[WORD_W-1:0];
  assign Cout = sum[WORD_W];

endmodule

// File: rtl/adder_arbiter_16bit.sv
// Two-requester arbiter around one shared add/subtract unit: grant, latch
// operands, execute from registers, then pulse ACK with registered results.
module adder_arbiter_16bit
  import adder_arbiter_16bit_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              S0,
  input  logic [WORD_W-1:0] A0,
  input  logic [WORD_W-1:0] B0,
  input  logic              REQ1,
  input  logic              S1,
  input  logic [WORD_W-1:0] A1,
  input  logic [WORD_W-1:0] B1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [WORD_W-1:0] Y,
  output logic              COUT,
  output logic              OVF,
  output logic              BUSY
);

  logic [ST_W-1:0]   state_q, state_d;
  operand_t          op_q, op_d;
  logic              gsel_q, gsel_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;

  logic              grant_sel;
  logic [WORD_W-1:0] add_y;
  logic              add_cout;

  // On a tie, round-robin picks whoever did not go last.
  assign grant_sel = (REQ0 && REQ1) ? (FAIR ? ~last_q : 1'b0) : REQ1;

  two_comple_adder_16bit u_adder (
    .S    (op_q.sub),
    .A    (op_q.a),
    .B    (op_q.b),
    .Y    (add_y),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    gsel_d  = gsel_q;
    last_d  = last_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          gsel_d  = grant_sel;
          op_d.sub = grant_sel ? S1 : S0;
          op_d.a   = grant_sel ? A1 : A0;
          op_d.b   = grant_sel ? B1 : B0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy_d  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        y_d     = add_y;
        cout_d  = add_cout;
        ovf_d   = calc_ovf(op_q.sub, op_q.a[WORD_W-1], op_q.b[WORD_W-1], add_y[WORD_W-1]);
        last_d  = gsel_q;
        ack0_d  = ~gsel_q;
        ack1_d  = gsel_q;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      gsel_q  <= 1'b0;
      last_q  <= 1'b1;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      gsel_q  <= gsel_d;
      last_q  <= last_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK0 = ack0_q;
  assign ACK1 = ack1_q;
  assign Y    = y_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;
  assign BUSY = busy_q;

endmodule
